// File: rtl/adder_test_pkg.sv
// Shared definitions for the exhaustive adder response checker:
// FSM states, default operand width and error counter width.
package adder_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int ERR_W         = 10;

    // Counter increment that sticks at all-ones
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/adder_vector_gen.sv
// Operand sweep counters: b innermost, a middle, carry-in outermost.
// Flags the final vector of the sweep for the controlling FSM.
module adder_vector_gen
    import adder_test_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             cin_en,
    input  logic             advance,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             ci,
    output logic             last
);

    logic cin_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a        <= '0;
            b        <= '0;
            ci       <= 1'b0;
            cin_en_q <= 1'b0;
        end else if (load) begin
            a        <= '0;
            b        <= '0;
            ci       <= 1'b0;
            cin_en_q <= cin_en;
        end else if (advance) begin
            if (b == '1) begin
                b <= '0;
                if (a == '1) begin
                    a  <= '0;
                    ci <= 1'b1;
                end else begin
                    a <= a + WIDTH'(1);
                end
            end else begin
                b <= b + WIDTH'(1);
            end
        end
    end

    // Without carry-in sweeping, ci never leaves 0, so the last vector is a=b=max
    assign last = (a == '1) && (b == '1) && (ci || !cin_en_q);

endmodule

// File: rtl/adder_response_checker.sv
// Exhaustive adder checker: drives every operand combination, waits for the
// adder to settle, compares its response and records the first mismatch.
module adder_response_checker
    import adder_test_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cin_en,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             ci_out,
    input  logic [WIDTH-1:0] s_in,
    input  logic             co_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_ci
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [7:0]       settle_cnt;
    logic             load;
    logic             advance;
    logic             last;
    logic [WIDTH:0]   exp_sum;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    assign load    = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    assign advance = (state == ST_CHECK) && !last;

    adder_vector_gen #(.WIDTH(WIDTH)) u_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .cin_en  (cin_en),
        .advance (advance),
        .a       (a_out),
        .b       (b_out),
        .ci      (ci_out),
        .last    (last)
    );

    assign exp_sum  = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, ci_out};
    assign mismatch = ({co_in, s_in} != exp_sum);
    assign err_next = mismatch ? sat_inc(err_count) : err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_ci    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_ci    <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= a_out;
                        fail_b     <= b_out;
                        fail_ci    <= ci_out;
                    end
                    if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/adder_response_checker.md
ADDER_RESPONSE_CHECKER -- requirements
Module: adder_response_checker

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width of the adder under test.
REQ-002 SHALL have parameter: SETTLE_CYCLES, 4, cycles operands are held before outputs are sampled (legal range 1..255).
REQ-003 SHALL have ports, clock and reset first; one clock; reset is synchronous and active-high:
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  start  in  1  begin sweep; honoured only in IDLE or DONE.
  cin_en  in  1  sampled with start; 1 = also sweep carry-in.
  a_out  out  WIDTH  operand A driven to adder.
  b_out  out  WIDTH  operand B driven to adder.
  ci_out  out  1  carry-in driven to adder.
  s_in  in  WIDTH  adder sum.
  co_in  in  1  adder carry-out.
  busy  out  1  sweep in progress.
  done  out  1  sweep finished; held until start or rst.
  pass  out  1  valid with done; 1 = zero mismatches.
  err_count  out  10  mismatch count, saturating at 1023.
  fail_valid  out  1  at least one mismatch captured.
  fail_a, fail_b  out  WIDTH each  operands of first mismatch.
  fail_ci  out  1  carry-in of first mismatch.

Function
REQ-004 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-005 IDLE/DONE + start=1 at an edge SHALL: enter SETTLE, load a_out=b_out=ci_out=0, latch cin_en, clear err_count, fail_*, done, pass.
REQ-006 SETTLE SHALL last exactly SETTLE_CYCLES cycles with operands stable, then go to CHECK.
REQ-007 CHECK SHALL last one cycle; expected {co,s} = a_out + b_out + ci_out computed at WIDTH+1 bits; mismatch if {co_in,s_in} differs.
REQ-008 On mismatch SHALL increment err_count (saturating); on first mismatch only, capture fail_a/fail_b/fail_ci and set fail_valid.
REQ-009 Sweep order SHALL be b_out innermost, a_out middle, ci_out outermost (ci_out fixed 0 when latched cin_en=0); vector count 2^(2*WIDTH), doubled with cin_en.
REQ-010 CHECK of a non-final vector SHALL advance operands on the same edge and return to SETTLE; operand wrap (b 15->0 increments a; a 15->0 increments ci) SHALL be exact.
REQ-011 CHECK of the final vector SHALL enter DONE: done=1, busy=0, pass=(err_count==0 after final compare).
REQ-012 busy SHALL be 1 exactly in SETTLE and CHECK; start while busy SHALL be ignored.
REQ-013 done SHALL assert (SETTLE_CYCLES+1)*N cycles after the start edge (N = vector count); 1280 for defaults, cin_en=0.
REQ-014 Operands SHALL hold their last value in DONE.

Reset
REQ-015 rst=1 at an edge SHALL force IDLE, a_out=b_out=0, ci_out=0, busy=done=pass=0, err_count=0, fail_valid=0, fail_a=fail_b=0, fail_ci=0; rst SHALL override start, including mid-sweep.

Structure
REQ-016 A shared package adder_test_pkg SHALL hold the state enumeration, default WIDTH, and error counter width.
REQ-017 One sub-module adder_vector_gen SHALL own the operand counters (load, advance, last flag); FSM, compare and capture stay in the top.

Verification
REQ-018 Correct behavioural adder, cin_en=0, defaults -> done at cycle 1280, pass=1, err_count=0, fail_valid=0.
REQ-019 Adder with co stuck at 0, cin_en=0 -> err_count=120, fail_a=1, fail_b=15, fail_ci=0, pass=0.
REQ-020 Adder with s[0] stuck at 1, cin_en=0 -> err_count=128, fail_a=0, fail_b=0, pass=0.
REQ-021 Correct adder, cin_en=1 -> 512 vectors, done at cycle 2560, pass=1; ci_out=1 first seen at vector 256.
REQ-022 rst pulsed at cycle 300 of a sweep -> all outputs at reset values next cycle; subsequent start sweeps from A=0,B=0 with err_count=0.
REQ-023 start pulsed while busy -> no effect on operands or timing; start pulsed in DONE -> restart with err_count, fail_*, done cleared.
